// File: rtl/mem_store_checker.sv
// Store monitor: compares data-memory writes against a programmable table, in order.
// Optional address window filter enabled by defining MWCHK_FILTER_EN.
module mem_store_checker #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1000,
    parameter int WIN_LO  = 0,
    parameter int WIN_HI  = 255,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              exp_we,
    input  logic [IW-1:0]     exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [NW-1:0]     num_exp,
    input  logic              start,
`ifdef MWCHK_FILTER_EN
    output logic [15:0]       filt_cnt,
`endif
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IW-1:0]     err_idx,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NW-1:0]     n_q, n_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              to_q, to_d;
    logic [IW-1:0]     eidx_q, eidx_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [DATA_W-1:0] edata_q, edata_d;
    logic [ADDR_W-1:0] tab_addr_q [DEPTH];
    logic [DATA_W-1:0] tab_data_q [DEPTH];

    logic store_v, hit, last, tmo, launch;

`ifdef MWCHK_FILTER_EN
    logic        in_win;
    logic [15:0] filt_q, filt_d;
    assign in_win = (({1'b0, dataadr} + (ADDR_W+1)'(1)) > (ADDR_W+1)'(WIN_LO))
                  && (dataadr <= ADDR_W'(WIN_HI));
    assign store_v = memwrite && in_win;
`else
    logic unused_win;
    assign unused_win = (WIN_LO > WIN_HI);
    assign store_v = memwrite;
`endif

    assign hit    = (dataadr == tab_addr_q[idx_q]) && (writedata == tab_data_q[idx_q]);
    assign last   = (NW'(idx_q) + NW'(1)) == n_q;
    assign tmo    = cnt_q == 32'(TIMEOUT - 1);
    assign launch = (state_q != S_RUN) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_PASS, S_FAIL: if (start) state_d = S_RUN;
            S_RUN: begin
                if (n_q == '0)   state_d = S_PASS;
                else if (store_v) state_d = !hit ? S_FAIL : (last ? S_PASS : S_RUN);
                else if (tmo)     state_d = S_FAIL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        pass = (state_q == S_PASS);
        fail = (state_q == S_FAIL);
    end

    // Datapath: a store on the timeout edge takes precedence over the timeout.
    always_comb begin
        idx_d   = idx_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        eidx_d  = eidx_q;
        eaddr_d = eaddr_q;
        edata_d = edata_q;
        if (launch) begin
            idx_d   = '0;
            n_d     = (num_exp > NW'(DEPTH)) ? NW'(DEPTH) : num_exp;
            cnt_d   = '0;
            to_d    = 1'b0;
            eidx_d  = '0;
            eaddr_d = '0;
            edata_d = '0;
        end else if (state_q == S_RUN) begin
            if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
            if (n_q != '0) begin
                if (store_v) begin
                    if (!hit) begin
                        eidx_d  = idx_q;
                        eaddr_d = dataadr;
                        edata_d = writedata;
                    end else if (!last) begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (tmo) begin
                    to_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            eidx_q  <= '0;
            eaddr_q <= '0;
            edata_q <= '0;
        end else begin
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            eidx_q  <= eidx_d;
            eaddr_q <= eaddr_d;
            edata_q <= edata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_addr_q[i] <= '0;
                tab_data_q[i] <= '0;
            end
        end else if (exp_we && state_q != S_RUN) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (exp_idx == IW'(i)) begin
                    tab_addr_q[i] <= exp_addr;
                    tab_data_q[i] <= exp_data;
                end
            end
        end
    end

`ifdef MWCHK_FILTER_EN
    always_comb begin
        filt_d = filt_q;
        if (launch) filt_d = '0;
        else if (state_q == S_RUN && memwrite && !in_win && filt_q != '1)
            filt_d = filt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) filt_q <= '0;
        else        filt_q <= filt_d;
    end

    assign filt_cnt = filt_q;
`endif

    assign timeout   = to_q;
    assign err_idx   = eidx_q;
    assign err_addr  = eaddr_q;
    assign err_data  = edata_q;
    assign cycle_cnt = cnt_q;

endmodule
